// File: rtl/fir_resp_pkg.sv
// Shared definitions for the FIR AXI-Lite/AXI-Stream responder:
// Lite FSM states, register byte addresses and ap_ctrl bit positions.
package fir_resp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_AR,
        S_R
    } lite_state_e;

    localparam int ADDR_CTRL     = 32'h000;
    localparam int ADDR_LEN      = 32'h010;
    localparam int ADDR_CNT      = 32'h014;
    localparam int ADDR_TAP_BASE = 32'h080;

    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_IDLE  = 2;

endpackage

// File: rtl/axil_axis_fir_responder_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head (dout_o).
// Ports: clk_i, rst_i (async, high), push_i/din_i, pop_i/dout_o,
// full_o, empty_o. Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axil_axis_fir_responder.sv
// AXI-Lite register slave plus AXI-Stream in/out FIFOs for the FIR MAC.
// Ports: Lite aw/w/ar/r channels, ss_* input stream, sm_* output stream,
// core_* MAC-side start/length/tap/stream interface. wb_clk_i, wb_rst_i
// (async, high). FIR_RESP_BEATCNT_EN maps beat_cnt read-only at 0x014.
module axil_axis_fir_responder
    import fir_resp_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    output logic                   core_start,
    output logic [31:0]            core_length,
    input  logic [3:0]             core_tap_idx,
    output logic [pDATA_WIDTH-1:0] core_tap_coef,
    output logic                   core_in_valid,
    input  logic                   core_in_ready,
    output logic [pDATA_WIDTH-1:0] core_in_data,
    input  logic                   core_out_valid,
    output logic                   core_out_ready,
    input  logic [pDATA_WIDTH-1:0] core_out_data
);

    lite_state_e            state_q;
    lite_state_e            state_d;
    logic [pADDR_WIDTH-1:0] addr_q;
    logic [pDATA_WIDTH-1:0] rdata_q;
    logic [pDATA_WIDTH-1:0] rd_mux;
    logic [pDATA_WIDTH-1:0] taps_q [Tape_Num];
    logic [31:0]            len_q;
    logic [31:0]            beat_cnt_q;
    logic                   ap_idle_q;
    logic                   ap_done_q;
    logic                   core_start_q;

    logic [pADDR_WIDTH-3:0] word;
    logic                   is_ctrl;
    logic                   is_len;
    logic [Tape_Num-1:0]    tap_hit;
    logic                   wr_fire;
    logic                   start_fire;
    logic                   cfg_wr;
    logic                   rd_ctrl_fire;
    logic                   sm_hs;
    logic                   last_beat;

    logic                   in_full;
    logic                   in_empty;
    logic                   out_full;
    logic                   out_empty;
    logic                   unused_ok;

    assign unused_ok = ^{ss_tlast, addr_q[1:0]};

    // Word-address decode of the latched Lite address.
    assign word    = addr_q[pADDR_WIDTH-1:2];
    assign is_ctrl = (int'(word) == (ADDR_CTRL >> 2));
    assign is_len  = (int'(word) == (ADDR_LEN >> 2));

    always_comb begin
        tap_hit = '0;
        for (int i = 0; i < Tape_Num; i++) begin
            tap_hit[i] = (int'(word) == (ADDR_TAP_BASE >> 2) + i);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (awvalid) begin
                    state_d = S_AW;
                end else if (arvalid) begin
                    state_d = S_AR;
                end
            end
            S_AW: begin
                awready = 1'b1;
                state_d = S_W;
            end
            S_W: begin
                wready = 1'b1;
                if (wvalid) begin
                    state_d = S_IDLE;
                end
            end
            S_AR: begin
                arready = 1'b1;
                state_d = S_R;
            end
            S_R: begin
                rvalid = 1'b1;
                if (rready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_fire      = (state_q == S_W) && wvalid;
    assign start_fire   = wr_fire && is_ctrl && wdata[CTRL_START] && ap_idle_q;
    assign cfg_wr       = wr_fire && ap_idle_q;
    assign rd_ctrl_fire = (state_q == S_R) && rready && is_ctrl;

    always_comb begin
        rd_mux = '0;
        if (is_ctrl) begin
            rd_mux[CTRL_DONE] = ap_done_q;
            rd_mux[CTRL_IDLE] = ap_idle_q;
        end else if (is_len) begin
            rd_mux = pDATA_WIDTH'(len_q);
        end
`ifdef FIR_RESP_BEATCNT_EN
        else if (int'(word) == (ADDR_CNT >> 2)) begin
            rd_mux = pDATA_WIDTH'(beat_cnt_q);
        end
`endif
        for (int i = 0; i < Tape_Num; i++) begin
            if (tap_hit[i]) begin
                rd_mux = taps_q[i];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == S_IDLE) begin
                if (awvalid) begin
                    addr_q <= awaddr;
                end else if (arvalid) begin
                    addr_q <= araddr;
                end
            end
            if (state_q == S_AR) begin
                rdata_q <= rd_mux;
            end
        end
    end

    // Configuration registers only accept writes while idle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            len_q <= '0;
            for (int i = 0; i < Tape_Num; i++) begin
                taps_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            if (is_len) begin
                len_q <= wdata[31:0];
            end
            for (int i = 0; i < Tape_Num; i++) begin
                if (tap_hit[i]) begin
                    taps_q[i] <= wdata;
                end
            end
        end
    end

    assign sm_hs     = sm_tvalid && sm_tready;
    assign last_beat = (beat_cnt_q == len_q - 32'd1);

    // Completion sets done before a concurrent ctrl read may clear it,
    // since that read captured the pre-completion status.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ap_idle_q    <= 1'b1;
            ap_done_q    <= 1'b0;
            core_start_q <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            core_start_q <= start_fire;
            if (start_fire) begin
                ap_idle_q  <= 1'b0;
                ap_done_q  <= 1'b0;
                beat_cnt_q <= '0;
            end else begin
                if (sm_hs) begin
                    beat_cnt_q <= beat_cnt_q + 32'd1;
                end
                if (!ap_idle_q && (len_q == '0)) begin
                    ap_idle_q <= 1'b1;
                    ap_done_q <= 1'b1;
                end else if (!ap_idle_q && sm_hs && last_beat) begin
                    ap_idle_q <= 1'b1;
                    ap_done_q <= 1'b1;
                end else if (rd_ctrl_fire) begin
                    ap_done_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        core_tap_coef = '0;
        for (int i = 0; i < Tape_Num; i++) begin
            if (int'(core_tap_idx) == i) begin
                core_tap_coef = taps_q[i];
            end
        end
    end

    assign rdata          = rdata_q;
    assign core_start     = core_start_q;
    assign core_length    = len_q;
    assign ss_tready      = !ap_idle_q && !in_full;
    assign core_in_valid  = !in_empty;
    assign core_out_ready = !out_full;
    assign sm_tvalid      = !out_empty;
    assign sm_tlast       = sm_tvalid && last_beat;

    sync_fifo #(
        .WIDTH (pDATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (ss_tvalid && ss_tready),
        .din_i   (ss_tdata),
        .pop_i   (core_in_valid && core_in_ready),
        .dout_o  (core_in_data),
        .full_o  (in_full),
        .empty_o (in_empty)
    );

    sync_fifo #(
        .WIDTH (pDATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (core_out_valid),
        .din_i   (core_out_data),
        .pop_i   (sm_hs),
        .dout_o  (sm_tdata),
        .full_o  (out_full),
        .empty_o (out_empty)
    );

endmodule

// File: tb/tb_axil_axis_fir_responder.sv
// Directed bench for axil_axis_fir_responder: register table,
// tap port, stream runs, busy lockout, backpressure and reset.
module tb_axil_axis_fir_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 0, wvalid = 0, arvalid = 0, rready = 0;
    logic        awready, wready, arready, rvalid;
    logic [11:0] awaddr = 0, araddr = 0;
    logic [31:0] wdata = 0, rdata;
    logic        ss_tvalid = 0, ss_tlast = 0, ss_tready;
    logic [31:0] ss_tdata = 0;
    logic        sm_tvalid, sm_tready = 1, sm_tlast;
    logic [31:0] sm_tdata;
    logic        core_start;
    logic [31:0] core_length;
    logic [3:0]  core_tap_idx = 0;
    logic [31:0] core_tap_coef;
    logic        core_in_valid, core_in_ready, core_out_valid, core_out_ready;
    logic [31:0] core_in_data, core_out_data;
    logic        loop_en = 0;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int smv_cnt = 0;
    logic [31:0] smq_d [$];
    logic        smq_l [$];

    always #5 clk = ~clk;

    // MAC stand-in: loops the input FIFO head into the output FIFO.
    assign core_in_ready  = loop_en && core_out_ready;
    assign core_out_valid = loop_en && core_in_valid;
    assign core_out_data  = core_in_data;

    axil_axis_fir_responder dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready),
        .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready),
        .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
        .core_start(core_start), .core_length(core_length),
        .core_tap_idx(core_tap_idx), .core_tap_coef(core_tap_coef),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_in_data(core_in_data),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .core_out_data(core_out_data)
    );

    always @(negedge clk) begin
        if (sm_tvalid && sm_tready) begin
            smq_d.push_back(sm_tdata);
            smq_l.push_back(sm_tlast);
        end
        if (core_start) start_cnt++;
        if (sm_tvalid) smv_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
        ss_tvalid = 0; loop_en = 0; sm_tready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic lite_write(input logic [11:0] a, input logic [31:0] d,
                              output int awc);
        bit done = 0;
        awc = 0;
        awvalid = 1; awaddr = a; wvalid = 1; wdata = d;
        for (int n = 0; n < 20 && !done; n++) begin
            @(posedge clk); #1;
            if (awready) begin awc++; awvalid = 0; end
            if (wready) begin @(posedge clk); #1; done = 1; end
        end
        awvalid = 0; wvalid = 0;
        if (!done) check("write_timeout", 32'd0, 32'd1);
    endtask

    task automatic lite_read(input logic [11:0] a, output logic [31:0] d,
                             output int arc);
        bit done = 0;
        arc = 0; d = '0;
        arvalid = 1; araddr = a; rready = 1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(posedge clk); #1;
            if (arready) begin arc++; arvalid = 0; end
            if (rvalid) begin d = rdata; @(posedge clk); #1; done = 1; end
        end
        arvalid = 0; rready = 0;
        if (!done) check("read_timeout", 32'd0, 32'd1);
    endtask

    task automatic ss_push(input logic [31:0] d, input int maxw,
                           output bit ok);
        ok = 0;
        ss_tvalid = 1; ss_tdata = d;
        for (int n = 0; n < maxw && !ok; n++) begin
            if (ss_tready) begin
                @(posedge clk); #1; ok = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        ss_tvalid = 0;
    endtask

    task automatic wait_sm(input int n);
        for (int c = 0; c < 200 && smq_d.size() < n; c++) begin
            @(posedge clk); #1;
        end
        check("sm_beats", 32'(smq_d.size()), 32'(n));
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t tbl [15];

    initial begin
        logic [31:0] rd;
        int          c;
        int          sb;
        int          qb;
        bit          ok;
        int          acc;
        logic [31:0] exp_cnt;

        for (int i = 0; i < 11; i++)
            tbl[i] = '{1'b1, 12'(32'h080 + 4*i), 32'(i+1), 32'(i+1)};
        tbl[11] = '{1'b1, 12'h040, 32'h55, 32'h0};
        tbl[12] = '{1'b1, 12'h0AC, 32'h99, 32'h0};
        tbl[13] = '{1'b1, 12'h014, 32'h77, 32'h0};
        tbl[14] = '{1'b0, 12'h010, 32'h0, 32'h0};

        do_reset();
        check("rst_awready", 32'(awready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", rdata, 0);
        check("rst_ss_tready", 32'(ss_tready), 0);
        check("rst_sm_tvalid", 32'(sm_tvalid), 0);
        check("rst_sm_tlast", 32'(sm_tlast), 0);
        check("rst_core_start", 32'(core_start), 0);
        check("rst_core_in_valid", 32'(core_in_valid), 0);
        check("rst_core_length", core_length, 0);
        lite_read(12'h000, rd, c);
        check("rst_ctrl", rd, 32'h4);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) begin
                lite_write(tbl[i].addr, tbl[i].wd, c);
                check($sformatf("awready_pulse_%0d", i), 32'(c), 1);
            end
        end
        for (int i = 0; i < 15; i++) begin
            lite_read(tbl[i].addr, rd, c);
            check($sformatf("reg_rd_%0h", tbl[i].addr), rd, tbl[i].exp);
            check($sformatf("arready_pulse_%0d", i), 32'(c), 1);
        end
        for (int i = 0; i < 16; i++) begin
            core_tap_idx = 4'(i);
            #1;
            check($sformatf("tap_port_%0d", i), core_tap_coef,
                  (i < 11) ? 32'(i+1) : 32'h0);
        end

        do_reset();
        lite_write(12'h080, 32'h1234, c);
        lite_write(12'h010, 32'd5, c);
        sb = start_cnt;
        lite_write(12'h000, 32'h1, c);
        repeat (3) @(posedge clk);
        #1;
        check("start_pulse", 32'(start_cnt - sb), 1);
        check("core_length", core_length, 32'd5);
        lite_read(12'h000, rd, c);
        check("ctrl_busy", rd, 32'h0);
        lite_write(12'h080, 32'hFFFF, c);
        lite_write(12'h010, 32'd9, c);
        lite_write(12'h000, 32'h1, c);
        repeat (3) @(posedge clk);
        #1;
        lite_read(12'h080, rd, c);
        check("busy_tap0", rd, 32'h1234);
        lite_read(12'h010, rd, c);
        check("busy_len", rd, 32'd5);
        check("busy_restart", 32'(start_cnt - sb), 1);

        do_reset();
        lite_write(12'h010, 32'd4, c);
        lite_write(12'h000, 32'h1, c);
        loop_en = 1;
        qb = smq_d.size();
        ss_push(32'd10, 10, ok);
        ss_push(32'd20, 10, ok);
        wait_sm(qb + 2);
`ifdef FIR_RESP_BEATCNT_EN
        exp_cnt = 32'd2;
`else
        exp_cnt = 32'd0;
`endif
        lite_read(12'h014, rd, c);
        check("beat_cnt_mid", rd, exp_cnt);
        ss_push(32'd30, 10, ok);
        ss_push(32'd40, 10, ok);
        wait_sm(qb + 4);
        for (int k = 0; k < 4; k++) begin
            if (qb + k < smq_d.size()) begin
                check($sformatf("run4_data_%0d", k), smq_d[qb+k],
                      32'(10*(k+1)));
                check($sformatf("run4_last_%0d", k), 32'(smq_l[qb+k]),
                      (k == 3) ? 32'd1 : 32'd0);
            end
        end
        lite_read(12'h000, rd, c);
        check("ctrl_done", rd, 32'h6);
        lite_read(12'h000, rd, c);
        check("ctrl_done_clr", rd, 32'h4);

        do_reset();
        lite_write(12'h010, 32'd6, c);
        lite_write(12'h000, 32'h1, c);
        @(posedge clk); #1;
        qb = smq_d.size();
        acc = 0;
        for (int k = 1; k <= 5; k++) begin
            ss_push(32'(k), 5, ok);
            if (ok) acc++;
        end
        check("fifo_accepted", 32'(acc), 32'd4);
        check("fifo_full_tready", 32'(ss_tready), 0);
        loop_en = 1;
        ss_push(32'd5, 20, ok);
        check("fifo_push5", 32'(ok), 1);
        ss_push(32'd6, 20, ok);
        check("fifo_push6", 32'(ok), 1);
        wait_sm(qb + 6);
        for (int k = 0; k < 6; k++) begin
            if (qb + k < smq_d.size()) begin
                check($sformatf("bp_data_%0d", k), smq_d[qb+k], 32'(k+1));
                check($sformatf("bp_last_%0d", k), 32'(smq_l[qb+k]),
                      (k == 5) ? 32'd1 : 32'd0);
            end
        end
        lite_read(12'h000, rd, c);
        check("bp_ctrl_done", rd, 32'h6);

        do_reset();
        qb = smv_cnt;
        lite_write(12'h000, 32'h1, c);
        @(posedge clk); #1;
        lite_read(12'h000, rd, c);
        check("len0_done", rd, 32'h6);
        check("len0_no_sm", 32'(smv_cnt - qb), 0);

        do_reset();
        lite_write(12'h010, 32'd3, c);
        lite_write(12'h000, 32'h1, c);
        arvalid = 1; araddr = 12'h000; rready = 0;
        for (int n = 0; n < 20 && !rvalid; n++) begin
            @(posedge clk); #1;
            if (arready) arvalid = 0;
        end
        check("sr_rvalid_before", 32'(rvalid), 1);
        arvalid = 0;
        rst = 1'b1;
        #1;
        check("sr_rst_rvalid", 32'(rvalid), 0);
        check("sr_rst_rdata", rdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        lite_read(12'h000, rd, c);
        check("sr_rst_idle", rd, 32'h4);
        lite_read(12'h010, rd, c);
        check("sr_rst_len", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
